// File: rtl/mem_pe_pkg.sv
// rtl/mem_pe_pkg.sv - command encodings and FSM state type shared by the memory PE.
package mem_pe_pkg;

    localparam logic [1:0] OP_WRITE = 2'b00;
    localparam logic [1:0] OP_READ  = 2'b01;
    localparam logic [1:0] OP_ACCUM = 2'b10;
    localparam logic [1:0] OP_CLEAR = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RMW  = 2'b01,
        CLR  = 2'b10
    } state_t;

endpackage

// File: rtl/mem_pe_regfile.sv
// rtl/mem_pe_regfile.sv - DEPTH x WORDSIZE register array, one write port, one combinational read port.
module mem_pe_regfile #(
    parameter int WORDSIZE = 16,
    parameter int MEMSIZE  = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                we,
    input  logic [MEMSIZE-1:0]  waddr,
    input  logic [WORDSIZE-1:0] wdata,
    input  logic [MEMSIZE-1:0]  raddr,
    output logic [WORDSIZE-1:0] rdata
);

    localparam int DEPTH = 2 ** MEMSIZE;

    logic [WORDSIZE-1:0] mem [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/mem_pe_ctrl.sv
// rtl/mem_pe_ctrl.sv - memory PE: write/read/accumulate/clear over a register file with auto-pointer.
// Optional MEM_PE_ACC_SATURATE_EN: saturating accumulate plus sticky sat_flag output.
module mem_pe_ctrl
    import mem_pe_pkg::*;
#(
    parameter int WORDSIZE = 16,
    parameter int MEMSIZE  = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [1:0]          cmd_op,
    input  logic                cmd_auto,
    input  logic [MEMSIZE-1:0]  cmd_addr,
    input  logic [WORDSIZE-1:0] data_in,
    output logic [WORDSIZE-1:0] data_out,
    output logic                out_valid,
    output logic                busy,
    output logic [MEMSIZE-1:0]  ptr
`ifdef MEM_PE_ACC_SATURATE_EN
    ,
    output logic                sat_flag
`endif
);

    state_t              state, state_nxt;
    logic                accept;
    logic [MEMSIZE-1:0]  ea;
    logic [MEMSIZE-1:0]  rmw_addr;
    logic [MEMSIZE-1:0]  clr_idx;
    logic [WORDSIZE-1:0] rmw_operand;
    logic [WORDSIZE-1:0] sum;
    logic                wr_en;
    logic [MEMSIZE-1:0]  wr_addr;
    logic [WORDSIZE-1:0] wr_data;
    logic [MEMSIZE-1:0]  rd_addr;
    logic [WORDSIZE-1:0] rd_data;

    assign cmd_ready = (state == IDLE) && !rst;
    assign accept    = cmd_valid && cmd_ready;
    assign ea        = cmd_auto ? ptr : cmd_addr;
    assign busy      = (state != IDLE);

`ifdef MEM_PE_ACC_SATURATE_EN
    logic [WORDSIZE:0] sum_ext;
    assign sum_ext = {1'b0, rd_data} + {1'b0, rmw_operand};
    assign sum     = sum_ext[WORDSIZE] ? '1 : sum_ext[WORDSIZE-1:0];
`else
    assign sum = rd_data + rmw_operand;
`endif

    mem_pe_regfile #(
        .WORDSIZE(WORDSIZE),
        .MEMSIZE (MEMSIZE)
    ) u_regfile (
        .clk  (clk),
        .rst  (rst),
        .we   (wr_en),
        .waddr(wr_addr),
        .wdata(wr_data),
        .raddr(rd_addr),
        .rdata(rd_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // The single write port is shared by IDLE writes, the RMW write-back and the clear sweep.
    always_comb begin
        state_nxt = state;
        wr_en     = 1'b0;
        wr_addr   = ea;
        wr_data   = data_in;
        rd_addr   = ea;
        case (state)
            IDLE: begin
                if (accept) begin
                    case (cmd_op)
                        OP_WRITE: wr_en = 1'b1;
                        OP_ACCUM: state_nxt = RMW;
                        OP_CLEAR: state_nxt = CLR;
                        default:  state_nxt = IDLE;
                    endcase
                end
            end
            RMW: begin
                rd_addr   = rmw_addr;
                wr_en     = 1'b1;
                wr_addr   = rmw_addr;
                wr_data   = sum;
                state_nxt = IDLE;
            end
            CLR: begin
                wr_en   = 1'b1;
                wr_addr = clr_idx;
                wr_data = '0;
                if (&clr_idx) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr         <= '0;
            data_out    <= '0;
            out_valid   <= 1'b0;
            rmw_addr    <= '0;
            rmw_operand <= '0;
            clr_idx     <= '0;
        end else begin
            out_valid <= 1'b0;
            if (accept) begin
                if (cmd_auto && (cmd_op != OP_CLEAR)) begin
                    ptr <= ptr + 1'b1;
                end
                case (cmd_op)
                    OP_READ: begin
                        data_out  <= rd_data;
                        out_valid <= 1'b1;
                    end
                    OP_ACCUM: begin
                        rmw_addr    <= ea;
                        rmw_operand <= data_in;
                    end
                    OP_CLEAR: clr_idx <= '0;
                    default: ;
                endcase
            end
            if (state == CLR) begin
                clr_idx <= clr_idx + 1'b1;
                if (&clr_idx) begin
                    ptr <= '0;
                end
            end
        end
    end

`ifdef MEM_PE_ACC_SATURATE_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sat_flag <= 1'b0;
        end else if (accept && (cmd_op == OP_CLEAR)) begin
            sat_flag <= 1'b0;
        end else if ((state == RMW) && sum_ext[WORDSIZE]) begin
            sat_flag <= 1'b1;
        end
    end
`endif

endmodule

// File: doc/mem_pe_ctrl.md
Name: mem_pe_ctrl

Overview:
- Parametrised memory-backed processing element.
- Successor to the fixed 16-bit, 8-word memory test block.
- Register-file storage with a valid/ready command port.
- Operations: write, read, accumulate (read-modify-write) and clear-all sweep.
- Direct-address mode and auto-increment pointer mode.
- Sits between a stream source and downstream datapath as a small scratch/accumulator bank.

Parameters:
- WORDSIZE, 16, data word width in bits.
- MEMSIZE, 3, address width; DEPTH = 2**MEMSIZE is a derived localparam, 8 words by default.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  block accepts a command this cycle.
- cmd_op  in  2  00 WRITE, 01 READ, 10 ACCUM, 11 CLEAR.
- cmd_auto  in  1  1 = use internal pointer; 0 = use cmd_addr.
- cmd_addr  in  MEMSIZE  direct address.
- data_in  in  WORDSIZE  write/accumulate operand.
- data_out  out  WORDSIZE  read result, held until the next read completes.
- out_valid  out  1  one-cycle pulse when data_out updates.
- busy  out  1  high while in RMW or CLR.
- ptr  out  MEMSIZE  current auto-pointer value.

Behaviour:
- Reset (async, rst=1):
  - FSM to IDLE, all memory words to 0.
  - data_out=0, out_valid=0, busy=0, ptr=0.
  - cmd_ready=0 while rst is high.
- Handshake:
  - Accept occurs on a rising edge with cmd_valid&&cmd_ready.
  - cmd_ready = (state==IDLE) && !rst.
- Effective address: ea = cmd_auto ? ptr : cmd_addr.
- Pointer:
  - ptr increments by 1 on every accepted WRITE/READ/ACCUM with cmd_auto=1.
  - Wraps DEPTH-1 -> 0.
  - Direct-mode commands leave ptr unchanged.
- FSM states: IDLE, RMW, CLR.
  - IDLE, WRITE: mem[ea]<=data_in on the accept edge; stay in IDLE.
  - IDLE, READ: data_out<=mem[ea] and out_valid=1 on the cycle after accept (1-cycle latency); stay in IDLE.
  - IDLE, ACCUM:
    - Latch ea and data_in; go to RMW.
    - In RMW: mem[ea] <= mem[ea] + operand (WORDSIZE bits, wraps mod 2^WORDSIZE); go back to IDLE.
    - Throughput is one ACCUM per 2 cycles.
  - IDLE, CLEAR:
    - Go to CLR with an internal sweep index=0.
    - Each cycle writes mem[index]<=0 and increments index.
    - After writing index DEPTH-1, return to IDLE and set ptr<=0.
    - Takes exactly DEPTH cycles; cmd_ready=0 throughout.
    - cmd_auto and cmd_addr are ignored.
- Read-after-write:
  - A READ accepted the cycle after a WRITE to the same address returns the new data.
  - A READ of an address accumulated in RMW returns the post-add value.
- out_valid is a single-cycle pulse and is never asserted for WRITE/ACCUM/CLEAR.
- cmd_valid while cmd_ready=0: the command is not consumed; the source must hold it.
- Reset mid-RMW or mid-CLR:
  - The operation is aborted and no partial write occurs after rst rises.
  - Memory returns to all-zero, FSM returns to IDLE.

Optional Feature:
- Macro: MEM_PE_ACC_SATURATE_EN.
- Defined:
  - ACCUM uses unsigned saturating add: if the sum exceeds 2^WORDSIZE-1, the stored word is all-ones.
  - Adds 1-bit output sat_flag, a sticky flag set on any saturation and cleared only by rst or CLEAR.
- Undefined: wrap-around add; no sat_flag port.

Decomposition:
- Package mem_pe_pkg holds:
  - op encodings OP_WRITE=2'b00, OP_READ=2'b01, OP_ACCUM=2'b10, OP_CLEAR=2'b11;
  - FSM state typedef {IDLE, RMW, CLR}.
- One natural sub-module: mem_pe_regfile.
  - DEPTH x WORDSIZE register array.
  - Async reset to zero, one write port, one combinational read port.
  - FSM, pointer and adder stay in mem_pe_ctrl.

Test Plan:
- Reset pulse from t=17 to 27 ns with a 40 ns clock period:
  - data_out=0, out_valid=0, ptr=0, cmd_ready=0 during rst, then 1.
- Auto-mode WRITE of 0x1111..0x8888 to all 8 words, then a 9th WRITE of 0xAAAA:
  - ptr wraps to 0 and mem[0]=0xAAAA.
  - Auto READs return 0xAAAA, 0x2222..0x8888 with one out_valid pulse each, 1 cycle after accept.
- Direct WRITE addr 5 = 0x0010, ACCUM addr 5 with 0x0005 twice, READ addr 5:
  - Returns 0x001A.
  - cmd_ready is low one cycle after each ACCUM accept.
- WRITE addr 2 = 0xFFFF, ACCUM addr 2 with 0x0003, READ addr 2:
  - Without macro: returns 0x0002.
  - With MEM_PE_ACC_SATURATE_EN: returns 0xFFFF and sat_flag=1.
- CLEAR after filling memory:
  - busy high and cmd_ready low for exactly 8 cycles.
  - All reads then return 0 and ptr=0.
- Assert rst during CLR sweep (index 3):
  - FSM to IDLE immediately and all words read back 0.
  - A following WRITE/READ of 0x1234 at addr 7 succeeds.
